instr_fetch_unit: RTL

Instruction fetch stage for the RISC-V core. Generates sequential word-aligned fetch addresses and issues them to instruction memory over a valid/ready request channel. It buffers in-order responses, each tagged with its PC, in a prefetch FIFO. It presents them to decode over a valid/ready channel, and a redirect from execute (branch or jump) flushes the buffered and in-flight instructions.

---
 rtl/riscv_pkg.sv | 18 +
 rtl/instr_fetch_unit_if.sv | 32 +++
 rtl/sync_fifo.sv | 85 ++++++++
 rtl/instr_fetch_unit.sv | 101 ++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Types and constants shared across the RISC-V core pipeline stages.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    // Instructions are word aligned, so the low two address bits are discarded.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory, execute (redirect) and decode.
interface instr_fetch_unit_if;
    import riscv_pkg::*;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
    // imem_req_* and instr_* are valid/ready pairs; imem_rsp_valid and redirect_valid
    // have no ready and are always accepted in the cycle they are high.
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [ILEN-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            instr_valid;
    logic            instr_ready;
    logic [ILEN-1:0] instr_out;
    logic [XLEN-1:0] instr_pc;

    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instr_out, instr_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
        input  instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instr_out, instr_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
        output instr_ready
    );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush and a registered head entry (no push-to-head bypass).
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             push_data_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    output logic                         valid_o,
    output logic [WIDTH-1:0]             head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_next;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] head_d;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i && (count_q != '0) && !flush_i;
    assign rd_next = rd_ptr_q + AW'(1);

    // The head register holds its last value when the FIFO empties or is flushed.
    always_comb begin
        head_d = head_q;
        if (do_pop) begin
            if (count_q > CW'(1)) begin
                head_d = mem_q[rd_next];
            end else if (do_push) begin
                head_d = push_data_i;
            end
        end else if (do_push && (count_q == '0)) begin
            head_d = push_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            head_q <= head_d;
            if (flush_i) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (do_push) begin
                    wr_ptr_q <= wr_ptr_q + AW'(1);
                end
                if (do_pop) begin
                    rd_ptr_q <= rd_next;
                end
                count_q <= count_q + CW'(do_push) - CW'(do_pop);
            end
        end
    end

    assign valid_o = (count_q != '0);
    assign head_o  = head_q;
    assign count_o = count_q;

    no_overflow_a: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push_i && !pop_i && !flush_i && (count_q == CW'(DEPTH))));

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: credit-limited sequential fetch, PC-tagged prefetch buffer, redirect flush.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    instr_fetch_unit_if.master    bus
);

    localparam int CW = $clog2(DEPTH+1);

    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] fetch_pc_d;
    logic [XLEN-1:0] shadow_pc_q;
    logic [XLEN-1:0] shadow_pc_d;
    logic [CW-1:0]   outstanding_q;
    logic [CW-1:0]   outstanding_d;
    logic [CW-1:0]   drop_q;
    logic [CW-1:0]   drop_d;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     credit_used;
    logic            req_valid;
    logic            req_fire;
    logic            rsp_keep;
    logic            fifo_valid;
    logic            pop;
    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;

    // In-flight requests plus buffered entries never exceed DEPTH, so every
    // response is guaranteed a FIFO slot.
    assign credit_used = {1'b0, outstanding_q} + {1'b0, fifo_count};
    assign req_valid   = !reset && !bus.redirect_valid && (credit_used < (CW+1)'(DEPTH));
    assign req_fire    = req_valid && bus.imem_req_ready;
    assign rsp_keep    = bus.imem_rsp_valid && !bus.redirect_valid && (drop_q == '0);
    assign pop         = fifo_valid && bus.instr_ready;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        shadow_pc_d   = shadow_pc_q;
        drop_d        = drop_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(bus.imem_rsp_valid);
        if (bus.redirect_valid) begin
            fetch_pc_d  = word_align(bus.redirect_pc);
            shadow_pc_d = word_align(bus.redirect_pc);
            // Everything still in flight after this edge belongs to the old path.
            drop_d      = outstanding_d;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (rsp_keep) begin
                shadow_pc_d = shadow_pc_q + 32'd4;
            end else if (bus.imem_rsp_valid) begin
                drop_d = drop_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            shadow_pc_q   <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            shadow_pc_q   <= shadow_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    assign push_entry.pc    = shadow_pc_q;
    assign push_entry.instr = bus.imem_rsp_data;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_prefetch_fifo (
        .clk_i       (clk),
        .rst_i       (reset),
        .push_i      (rsp_keep),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .flush_i     (bus.redirect_valid),
        .valid_o     (fifo_valid),
        .head_o      (head_entry),
        .count_o     (fifo_count)
    );

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc_q;
    assign bus.instr_valid    = fifo_valid;
    assign bus.instr_out      = head_entry.instr;
    assign bus.instr_pc       = head_entry.pc;

endmodule
